// File: rtl/alu_issue_arbiter.sv
// Round-robin issue front end sharing one pipelined ALU among NUM_REQ requesters.
// Each result returns through a credit-guarded FWFT FIFO, tagged with its requester.
`timescale 1ns/1ps
module alu_issue_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 32,
   parameter int ALU_LAT   = 2,
   parameter int RSP_DEPTH = 4,
   localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [4*NUM_REQ-1:0]     req_opcode,
   input  logic [WIDTH*NUM_REQ-1:0] req_a,
   input  logic [WIDTH*NUM_REQ-1:0] req_b,
   input  logic [5*NUM_REQ-1:0]     req_shift,
   output logic [3:0]               alu_opcode,
   output logic [WIDTH-1:0]         alu_input1,
   output logic [WIDTH-1:0]         alu_input2,
   output logic [4:0]               alu_shift,
   input  logic [WIDTH-1:0]         alu_result,
   input  logic [3:0]               alu_flags,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_result,
   output logic [3:0]               rsp_flags,
   output logic                     rsp_err,
   output logic                     busy
);

   localparam int STAGES = ALU_LAT + 1;
   localparam int PTR_W  = $clog2(RSP_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int OCC_W  = $clog2(RSP_DEPTH + STAGES + 1);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            err;
   } tag_t;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic             err;
      logic [3:0]       flags;
      logic [WIDTH-1:0] result;
   } rsp_t;

   tag_t             tag_q [STAGES];
   rsp_t             fifo_mem [RSP_DEPTH];
   rsp_t             head;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OCC_W-1:0] occ;
   logic [ID_W-1:0]  last_q, grant_id, cand;
   logic             grant_vld, credit_ok, accept, push, pop;
   logic [3:0]       sel_opcode;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [4:0]       sel_shift;
   logic             sel_err;
   logic [3:0]       alu_opcode_q;
   logic [WIDTH-1:0] alu_input1_q, alu_input2_q;
   logic [4:0]       alu_shift_q;

   function automatic logic [ID_W-1:0] wrap_id(input int n);
      return ID_W'(n % NUM_REQ);
   endfunction

   // Every accepted op is either in the tag pipeline or the FIFO until popped.
   always_comb begin
      occ = OCC_W'(cnt_q);
      for (int s = 0; s < STAGES; s++) occ = occ + OCC_W'(tag_q[s].valid);
   end

   assign credit_ok = (occ < OCC_W'(RSP_DEPTH));
   assign busy      = (occ != '0);

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = wrap_id(int'(last_q) + k);
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_id  = cand;
         end
      end
   end

   assign accept = grant_vld & credit_ok & rst_n;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      sel_opcode = req_opcode[4*int'(grant_id) +: 4];
      sel_a      = req_a[WIDTH*int'(grant_id) +: WIDTH];
      sel_b      = req_b[WIDTH*int'(grant_id) +: WIDTH];
      sel_shift  = req_shift[5*int'(grant_id) +: 5];
      sel_err    = (sel_opcode == 4'd5) || (sel_opcode >= 4'd10);
   end

   assign push  = tag_q[STAGES-1].valid;
   assign pop   = rsp_valid & rsp_ready;
   assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q       <= ID_W'(NUM_REQ - 1);
         alu_opcode_q <= '0;
         alu_input1_q <= '0;
         alu_input2_q <= '0;
         alu_shift_q  <= '0;
         for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
      end else begin
         tag_q[0] <= '0;
         if (accept) begin
            last_q       <= grant_id;
            alu_opcode_q <= sel_opcode;
            alu_input1_q <= sel_a;
            alu_input2_q <= sel_b;
            alu_shift_q  <= sel_shift;
            tag_q[0]     <= '{valid: 1'b1, id: grant_id, err: sel_err};
         end
         for (int s = 1; s < STAGES; s++) tag_q[s] <= tag_q[s-1];
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_d;
      end
   end

   // NOTE: FIFO storage is not reset; the count alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_q] <= '{id: tag_q[STAGES-1].id, err: tag_q[STAGES-1].err,
                                 flags: alu_flags, result: alu_result};
   end

   assign head       = fifo_mem[rd_ptr_q];
   assign rsp_valid  = (cnt_q != '0);
   assign rsp_id     = rsp_valid ? head.id     : '0;
   assign rsp_err    = rsp_valid ? head.err    : 1'b0;
   assign rsp_flags  = rsp_valid ? head.flags  : '0;
   assign rsp_result = rsp_valid ? head.result : '0;

   assign alu_opcode = alu_opcode_q;
   assign alu_input1 = alu_input1_q;
   assign alu_input2 = alu_input2_q;
   assign alu_shift  = alu_shift_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: a two-stage ALU model plus a transaction-level
// reference (outstanding-op queue, round-robin pointer) checked every cycle.
`timescale 1ns/1ps
module tb_alu_issue_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int WIDTH     = 32;
   localparam int ALU_LAT   = 2;
   localparam int RSP_DEPTH = 4;
   localparam int ID_W      = $clog2(NUM_REQ);

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                          OP_XOR = 4'd4, OP_SGT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                          OP_MUL = 4'd8, OP_SRA = 4'd9;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic [4*NUM_REQ-1:0]     req_opcode = '0;
   logic [WIDTH*NUM_REQ-1:0] req_a = '0;
   logic [WIDTH*NUM_REQ-1:0] req_b = '0;
   logic [5*NUM_REQ-1:0]     req_shift = '0;
   logic [3:0]               alu_opcode;
   logic [WIDTH-1:0]         alu_input1, alu_input2;
   logic [4:0]               alu_shift;
   logic [WIDTH-1:0]         alu_result = '0;
   logic [3:0]               alu_flags = '0;
   logic                     rsp_valid;
   logic                     rsp_ready = 1'b0;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_result;
   logic [3:0]               rsp_flags;
   logic                     rsp_err;
   logic                     busy;

   always #5 clk = ~clk;

   alu_issue_arbiter #(
      .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
      .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
      .alu_shift(alu_shift), .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
   );

   // Returns {carry, zero, overflow, sign, result}.
   function automatic logic [WIDTH+3:0] alu_eval(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y, input logic [4:0] sh);
      logic [WIDTH:0]   w;
      logic [WIDTH-1:0] r;
      logic             c, v;
      c = 1'b0; v = 1'b0; w = '0; r = '0;
      case (op)
         OP_ADD: begin
            w = {1'b0, x} + {1'b0, y}; r = w[WIDTH-1:0]; c = w[WIDTH];
            v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
         end
         OP_SUB: begin
            w = {1'b0, x} - {1'b0, y}; r = w[WIDTH-1:0]; c = w[WIDTH];
            v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
         end
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         OP_SLL:  r = x << sh;
         OP_SRL:  r = x >> sh;
         OP_MUL:  r = x * y;
         OP_SRA:  r = $signed(x) >>> sh;
         default: r = 32'hDEAD_BEEF;
      endcase
      return {c, (r == '0), v, r[WIDTH-1], r};
   endfunction

   // ALU stand-in: input register stage then output register stage.
   logic [3:0]       a_op_q = '0;
   logic [WIDTH-1:0] a_x_q = '0, a_y_q = '0;
   logic [4:0]       a_sh_q = '0;
   always @(posedge clk) begin
      a_op_q <= alu_opcode;
      a_x_q  <= alu_input1;
      a_y_q  <= alu_input2;
      a_sh_q <= alu_shift;
      {alu_flags, alu_result} <= alu_eval(a_op_q, a_x_q, a_y_q, a_sh_q);
   end

   typedef struct {
      logic [ID_W-1:0]  id;
      logic             err;
      logic [WIDTH-1:0] result;
      logic [3:0]       flags;
      int unsigned      ready_cyc;
   } exp_t;

   typedef struct {
      logic [ID_W-1:0]  id;
      logic             err;
      logic [WIDTH-1:0] result;
   } pop_t;

   exp_t        exp_q[$];
   pop_t        obs_pop[$];
   int          obs_grants[$];
   int          last_grant  = NUM_REQ - 1;
   int          model_grant = -1;
   int          obs_grant   = -1;
   int unsigned cycle       = 0;
   int          n_acc       = 0;
   int          checks      = 0;
   int          errors      = 0;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [4:0] sh);
      req_opcode[4*i +: 4]       = op;
      req_a[WIDTH*i +: WIDTH]    = a;
      req_b[WIDTH*i +: WIDTH]    = b;
      req_shift[5*i +: 5]        = sh;
   endtask

   task automatic rand_req(input int i);
      set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
   endtask

   // One clock cycle: drive, predict, compare, then advance the reference model.
   task automatic step(input logic [NUM_REQ-1:0] vmask, input logic rdy);
      logic vis;
      exp_t e;
      int   n_out;
      req_valid = vmask;
      rsp_ready = rdy;
      #1;
      n_out = exp_q.size();
      model_grant = -1;
      if (n_out < RSP_DEPTH)
         for (int k = 1; k <= NUM_REQ; k++)
            if (model_grant < 0 && vmask[(last_grant + k) % NUM_REQ])
               model_grant = (last_grant + k) % NUM_REQ;
      check("req_ready", req_ready, (model_grant >= 0) ? (64'd1 << model_grant) : 64'd0);
      vis = (n_out > 0) && (exp_q[0].ready_cyc <= cycle);
      check("rsp_valid", rsp_valid, vis);
      if (vis) begin
         check("rsp_id", rsp_id, exp_q[0].id);
         check("rsp_err", rsp_err, exp_q[0].err);
         if (!exp_q[0].err) begin
            check("rsp_result", rsp_result, exp_q[0].result);
            check("rsp_flags", rsp_flags, exp_q[0].flags);
         end
      end
      check("busy", busy, n_out != 0);
      obs_grant = -1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) obs_grant = i;
      if (obs_grant >= 0) begin
         n_acc++;
         obs_grants.push_back(obs_grant);
      end
      if (rsp_valid && rdy) obs_pop.push_back('{id: rsp_id, err: rsp_err, result: rsp_result});
      @(posedge clk);
      cycle++;
      if (vis && rdy) void'(exp_q.pop_front());
      if (model_grant >= 0) begin
         e.id  = ID_W'(model_grant);
         e.err = (req_opcode[4*model_grant +: 4] == OP_SGT) || (req_opcode[4*model_grant +: 4] >= 4'd10);
         {e.flags, e.result} = alu_eval(req_opcode[4*model_grant +: 4], req_a[WIDTH*model_grant +: WIDTH],
                                        req_b[WIDTH*model_grant +: WIDTH], req_shift[5*model_grant +: 5]);
         e.ready_cyc = cycle + ALU_LAT + 1;
         exp_q.push_back(e);
         last_grant = model_grant;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) step('0, 1'b1);
      #1 check("idle_after_drain", busy, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, '0);
      check({tag, "_alu_opcode"}, alu_opcode, '0);
      check({tag, "_alu_input1"}, alu_input1, '0);
      check({tag, "_alu_input2"}, alu_input2, '0);
      check({tag, "_alu_shift"}, alu_shift, '0);
      check({tag, "_rsp_valid"}, rsp_valid, '0);
      check({tag, "_rsp_id"}, rsp_id, '0);
      check({tag, "_rsp_result"}, rsp_result, '0);
      check({tag, "_rsp_flags"}, rsp_flags, '0);
      check({tag, "_rsp_err"}, rsp_err, '0);
      check({tag, "_busy"}, busy, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int issued;

      // Reset with every requester asking.
      for (int i = 0; i < NUM_REQ; i++) rand_req(i);
      req_valid = '1;
      repeat (2) @(negedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single ADD from requester 2, carry out and zero result.
      set_req(2, OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
      step(4'b0100, 1'b0);
      check("t1_grant", obs_grant, 2);
      check("t1_alu_opcode", alu_opcode, OP_ADD);
      check("t1_alu_input1", alu_input1, 32'hFFFF_FFFF);
      check("t1_alu_input2", alu_input2, 32'd1);
      repeat (3) step('0, 1'b0);
      #1;
      check("t1_rsp_valid", rsp_valid, 1'b1);
      check("t1_rsp_id", rsp_id, 2);
      check("t1_rsp_result", rsp_result, 32'd0);
      check("t1_carry", rsp_flags[3], 1'b1);
      check("t1_rsp_err", rsp_err, 1'b0);
      drain();

      // Round-robin with all requesters active.
      obs_grants.delete();
      obs_pop.delete();
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'($urandom_range(0, 9)), $urandom, $urandom, 5'($urandom_range(0, 31)));
         step('1, 1'b1);
      end
      drain();
      check("t2_grant_count_ge_12", obs_grants.size() >= 12, 1'b1);
      check("t2_pop_count", obs_pop.size(), obs_grants.size());
      foreach (obs_grants[k]) check("t2_grant_order", obs_grants[k], (3 + k) % NUM_REQ);
      foreach (obs_pop[k]) check("t2_rsp_id_order", obs_pop[k].id, (3 + k) % NUM_REQ);

      // Backpressure: credit caps in-flight work at RSP_DEPTH.
      n_acc = 0;
      obs_pop.delete();
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < NUM_REQ; i++) rand_req(i);
         step('1, 1'b0);
      end
      check("t3_accepts_stalled", n_acc, RSP_DEPTH);
      step('1, 1'b1);
      repeat (5) step('1, 1'b0);
      check("t3_accepts_after_one_pop", n_acc, RSP_DEPTH + 1);
      drain();
      check("t3_responses", obs_pop.size(), RSP_DEPTH + 1);

      // Unsupported opcodes back-to-back.
      obs_pop.delete();
      set_req(1, OP_SGT, 32'd7, 32'd3, 5'd0);
      step(4'b0010, 1'b1);
      set_req(1, 4'd12, 32'd9, 32'd4, 5'd1);
      step(4'b0010, 1'b1);
      drain();
      check("t4_responses", obs_pop.size(), 2);
      foreach (obs_pop[k]) begin
         check("t4_err", obs_pop[k].err, 1'b1);
         check("t4_id", obs_pop[k].id, 1);
      end

      // Reset with two ops in the pipeline and two in the FIFO.
      for (int i = 0; i < NUM_REQ; i++) rand_req(i);
      repeat (5) step('1, 1'b0);
      req_valid = '1;
      rst_n = 1'b0;
      #1 check_reset_outputs("mid_reset");
      exp_q.delete();
      last_grant = NUM_REQ - 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t5_busy_after_release", busy, 1'b0);
      check("t5_rsp_valid_after_release", rsp_valid, 1'b0);
      step('1, 1'b1);
      check("t5_first_grant", obs_grant, 0);
      repeat (3) step('0, 1'b1);
      drain();

      // FIFO pointer wrap under toggling backpressure.
      obs_pop.delete();
      issued = 0;
      for (int c = 0; c < 200 && (issued < 20 || exp_q.size() > 0); c++) begin
         set_req(3, OP_MUL, WIDTH'(issued), 32'd3, 5'd0);
         step((issued < 20) ? 4'b1000 : 4'b0000, c[0]);
         if (model_grant == 3) issued++;
      end
      check("t6_responses", obs_pop.size(), 20);
      foreach (obs_pop[k]) begin
         check("t6_result", obs_pop[k].result, 64'(3 * k));
         check("t6_id", obs_pop[k].id, 3);
      end

      // Random traffic against the reference model.
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NUM_REQ; i++) rand_req(i);
         step(NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)), $urandom_range(0, 3) != 0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
